// File: rtl/slv_frame_source.sv
// slv_frame_source: streams one SRAM-resident frame of DW-bit words onto an arbiter slave channel.
// Define SLV_SRC_PERF_EN to add the 32-bit saturating stall_cnt output.
module slv_frame_source #(
  parameter int DW = 32,
  parameter int AW = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_proc,
  input  logic [AW-1:0] cfg_base,
  input  logic [LW-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic [1:0]    slv_mode,
  output logic          slv_data_valid,
  output logic          slv_proc_valid,
  output logic [DW-1:0] slv_data,
  input  logic          slv_ready,
`ifdef SLV_SRC_PERF_EN
  output logic [31:0]   stall_cnt,
`endif
  input  logic          mstr_cmplt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic          proc_q;
  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] fetch_idx;
  logic [LW-1:0] sent_cnt;
  logic          rd_pend;
  logic [DW-1:0] buf_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ;
  logic          in_run;
  logic          accept;
  logic          xfer;
  logic          last_xfer;
  logic [2:0]    committed;

  assign in_run         = (state == ST_RUN);
  assign accept         = (state == ST_IDLE) && start && (cfg_mode != 2'd0);
  assign busy           = in_run;
  assign slv_data_valid = in_run && (occ != 2'd0);
  assign slv_mode       = in_run ? mode_q : 2'd0;
  assign slv_proc_valid = slv_data_valid && proc_q;
  assign slv_data       = buf_mem[rd_ptr];
  assign xfer           = slv_data_valid && slv_ready;
  assign last_xfer      = xfer && ((sent_cnt + LW'(1)) == len_q);

  // Buffer slots already claimed, crediting this cycle's pop so reads keep pace with a full-rate ready.
  assign committed = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, xfer};
  assign mem_rd_en = in_run && !mstr_cmplt && (fetch_idx < len_q) && (committed < 3'd2);
  assign mem_addr  = base_q + AW'(fetch_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      mode_q     <= 2'd0;
      proc_q     <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      fetch_idx  <= '0;
      sent_cnt   <= '0;
      rd_pend    <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q    <= cfg_mode;
            proc_q    <= cfg_proc;
            base_q    <= cfg_base;
            len_q     <= cfg_len;
            fetch_idx <= '0;
            sent_cnt  <= '0;
            rd_pend   <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            if (cfg_len == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Abort drops buffered words and ignores the read still returning from the SRAM.
          if (mstr_cmplt) begin
            state   <= ST_IDLE;
            mode_q  <= 2'd0;
            proc_q  <= 1'b0;
            rd_pend <= 1'b0;
            occ     <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
          end else begin
            rd_pend <= mem_rd_en;
            if (mem_rd_en)
              fetch_idx <= fetch_idx + LW'(1);
            if (rd_pend) begin
              buf_mem[wr_ptr] <= mem_rd_data;
              wr_ptr          <= ~wr_ptr;
            end
            if (xfer) begin
              rd_ptr   <= ~rd_ptr;
              sent_cnt <= sent_cnt + LW'(1);
            end
            occ <= occ + {1'b0, rd_pend} - {1'b0, xfer};
            if (last_xfer) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          if (mstr_cmplt) begin
            mode_q <= 2'd0;
            proc_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SLV_SRC_PERF_EN
  // Saturating count of cycles the arbiter holds off a presented word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (accept)
      stall_cnt <= '0;
    else if (slv_data_valid && !slv_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
